mat_mac_seq: RTL and testbench
==============================

MAT_MAC_SEQ -- requirements
Module: mat_mac_seq

Interface
REQ-001 The block SHALL have parameter WII, default 8: integer bits per fixed-point word, two's complement.
REQ-002 The block SHALL have parameter WIF, default 8: fractional bits per word; word width W = WII+WIF.
REQ-003 The block SHALL have parameter N, default 4: square matrix dimension, 2..8.
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operands present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-008 The block SHALL have port chain, input, 1 bit: when 1 at accept, A operand = current res_mat and mat_a is ignored.
REQ-009 The block SHALL have port mat_a, input, N*N x W: row-major, element [r*N+c].
REQ-010 The block SHALL have port mat_b, input, N*N x W: row-major.
REQ-011 The block SHALL have port out_valid, output, 1 bit: res_mat complete.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer takes result.
REQ-013 The block SHALL have port res_mat, output, N*N x W: row-major result A*B.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky saturation flag for the current result.

Function
REQ-015 States SHALL be IDLE, BUSY and DONE; in_ready SHALL equal (state==IDLE), combinationally.
REQ-016 Accept SHALL be defined as in_valid&&in_ready at an edge; on accept, A and B SHALL be latched, element index k cleared to 0, overflow cleared, and the state SHALL go to BUSY.
REQ-017 In BUSY, each cycle SHALL compute element k = sum over j of A[r][j]*B[j][c], with r=k/N and c=k%N, using N parallel signed multipliers; it SHALL write res_mat[k] at the edge and then increment k.
REQ-018 Products SHALL be summed at full precision: 2W+clog2(N) bits with 2*WIF fractional bits, and no intermediate rounding or saturation.
REQ-019 The sum SHALL be reduced once to WII.WIF by round-half-up (add 2^(WIF-1) at the 2*WIF scale, then drop the low WIF bits), then saturated to [0x7F..F, 0x80..0].
REQ-020 Any saturation during an operation SHALL set overflow until the next accept or Reset.
REQ-021 After writing element N*N-1, the state SHALL go to DONE; out_valid SHALL be 1 exactly in DONE; latency SHALL be N*N cycles from the accept edge to out_valid high.
REQ-022 In DONE, res_mat and overflow SHALL hold stable; on out_valid&&out_ready the state SHALL go to IDLE.
REQ-023 The earliest next accept SHALL be the cycle after handoff; there is no accept while BUSY or DONE, and in_valid is ignored then.
REQ-024 res_mat SHALL retain its value in IDLE; chain SHALL use that retained value, so P*V*M is computed as two chained operations.
REQ-025 Elements not yet written in BUSY SHALL hold their previous values; consumers SHALL read res_mat only when out_valid is 1.

Reset
REQ-026 When Reset is 1 at an edge, in any state including mid-BUSY, the state SHALL go to IDLE, k=0, res_mat=0, overflow=0 and out_valid=0, and the in-flight operation SHALL be discarded.
REQ-027 After reset, a chained operation SHALL use A = all-zero.

Structure
REQ-028 Package mat_pkg SHALL hold the default WII/WIF/N constants, the state enum typedef (IDLE/BUSY/DONE) and the accumulator-width function.
REQ-029 Rounding and saturation SHALL live in one sub-module, fxp_round_sat: it takes the accumulator in and returns a W-bit word and an overflow bit, combinationally.

Verification
REQ-030 Identity scenario: A=identity (0x0100 diagonal), B = elements 0x0000..0x0F00 -> res_mat==B, out_valid rises exactly 16 cycles after accept, overflow=0.
REQ-031 Saturation scenario: A all 0x7F00, B all 0x0200 -> every element 0x7FFF, overflow=1; A all 0x8100, B all 0x0200 -> 0x8000, overflow=1.
REQ-032 Rounding scenario: A[0][0]=0x0001, B[0][0]=0x0080, others 0 -> res[0]=0x0001; B[0][0]=0x007F -> res[0]=0x0000.
REQ-033 Back-pressure scenario: out_ready low 5 cycles in DONE with in_valid high -> res_mat stable, in_ready=0, no accept; handoff then accept on the next cycle.
REQ-034 Chain scenario: accept P=2*I, then chain=1 with B=3*I -> 6*I (0x0600 diagonal).
REQ-035 Reset scenario: Reset at BUSY cycle 7 -> next cycle IDLE, res_mat=0, out_valid=0; a following chain accept yields all zero.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared constants, FSM state type and accumulator sizing for the sequential
// fixed-point matrix multiplier.
package mat_pkg;

    localparam int WII_DEF = 8;
    localparam int WIF_DEF = 8;
    localparam int N_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Full-precision dot-product width: double-width products plus growth for N terms.
    function automatic int acc_width(input int w, input int n);
        return 2 * w + $clog2(n);
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Reduces a full-precision dot product (2*WIF fractional bits) to a WII.WIF
// word with round-half-up, then clamps to the signed word range.
module fxp_round_sat
    import mat_pkg::*;
#(
    parameter int WII = WII_DEF,
    parameter int WIF = WIF_DEF,
    parameter int AW  = acc_width(WII + WIF, N_DEF)
) (
    input  logic signed [AW-1:0]      acc_i,
    output logic        [WII+WIF-1:0] word_o,
    output logic                      ovf_o
);

    localparam int W = WII + WIF;
    localparam logic signed [AW:0] HALF_C = {{(AW-WIF+1){1'b0}}, 1'b1, {(WIF-1){1'b0}}};

    logic signed [AW:0]     rnd_s;
    logic signed [AW:0]     sh_s;
    logic        [AW-W+1:0] top_s;

    // One guard bit so adding the half-LSB can never wrap.
    assign rnd_s = {acc_i[AW-1], acc_i} + HALF_C;
    assign sh_s  = rnd_s >>> WIF;
    assign top_s = sh_s[AW:W-1];

    // Result fits only if every bit above the word is a copy of its sign bit.
    always_comb begin
        word_o = sh_s[W-1:0];
        ovf_o  = 1'b0;
        if ((&top_s) || (~|top_s)) begin
            word_o = sh_s[W-1:0];
            ovf_o  = 1'b0;
        end else if (sh_s[AW]) begin
            word_o = {1'b1, {(W-1){1'b0}}};
            ovf_o  = 1'b1;
        end else begin
            word_o = {1'b0, {(W-1){1'b1}}};
            ovf_o  = 1'b1;
        end
    end

endmodule

// File: rtl/mat_mac_seq.sv
// Sequential N x N fixed-point matrix multiplier: one result element per cycle
// from N parallel signed multipliers, optional chaining of the previous result as A.
module mat_mac_seq
    import mat_pkg::*;
#(
    parameter int WII = WII_DEF,
    parameter int WIF = WIF_DEF,
    parameter int N   = N_DEF
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             chain,
    input  logic [N*N-1:0][WII+WIF-1:0]      mat_a,
    input  logic [N*N-1:0][WII+WIF-1:0]      mat_b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N*N-1:0][WII+WIF-1:0]      res_mat,
    output logic                             overflow
);

    localparam int W  = WII + WIF;
    localparam int AW = acc_width(W, N);
    localparam int KW = $clog2(N * N);
    localparam logic [KW-1:0] K_LAST = KW'(N * N - 1);
    localparam logic [KW-1:0] N_K    = KW'(N);

    state_e                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [N*N-1:0][W-1:0]   a_q, a_d;
    logic [N*N-1:0][W-1:0]   b_q, b_d;
    logic [N*N-1:0][W-1:0]   res_q, res_d;
    logic                    ovf_q, ovf_d;

    logic [KW-1:0]           row_s, col_s;
    logic signed [2*W-1:0]   prod_s [N];
    logic signed [AW-1:0]    acc_s;
    logic [W-1:0]            word_s;
    logic                    ovf_s;

    assign row_s = k_q / N_K;
    assign col_s = k_q % N_K;

    for (genvar j = 0; j < N; j++) begin : g_mul
        logic [KW-1:0] a_idx_s;
        logic [KW-1:0] b_idx_s;
        assign a_idx_s   = row_s * N_K + KW'(j);
        assign b_idx_s   = KW'(j) * N_K + col_s;
        assign prod_s[j] = (2*W)'($signed(a_q[a_idx_s])) * (2*W)'($signed(b_q[b_idx_s]));
    end

    // Exact sum of the N products for the element selected by k.
    always_comb begin
        acc_s = '0;
        for (int j = 0; j < N; j++) begin
            acc_s = acc_s + AW'(prod_s[j]);
        end
    end

    fxp_round_sat #(
        .WII (WII),
        .WIF (WIF),
        .AW  (AW)
    ) u_round_sat (
        .acc_i  (acc_s),
        .word_o (word_s),
        .ovf_o  (ovf_s)
    );

    // Next-state logic: accept in IDLE, one element per cycle in BUSY, hold in DONE.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = chain ? res_q : mat_a;
                    b_d     = mat_b;
                    k_d     = '0;
                    ovf_d   = 1'b0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                res_d[k_q] = word_s;
                ovf_d      = ovf_q | ovf_s;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d     = k_q + KW'(1'b1);
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign res_mat   = res_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mat_mac_seq.sv
// Directed bench for mat_mac_seq with an integer-arithmetic reference model.
module tb_mat_mac_seq;

    localparam int WII = 8;
    localparam int WIF = 8;
    localparam int N   = 4;
    localparam int W   = WII + WIF;
    localparam int NE  = N * N;

    typedef logic [NE-1:0][W-1:0] mat_t;

    logic Clk = 1'b0;
    logic Reset, in_valid, in_ready, chain, out_valid, out_ready, overflow;
    mat_t mat_a, mat_b, res_mat;

    int   checks = 0;
    int   errors = 0;
    mat_t exp_res, model_res, held, ramp, ma, mb;
    logic exp_ovf;

    always #5 Clk = ~Clk;

    mat_mac_seq #(.WII(WII), .WIF(WIF), .N(N)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .chain     (chain),
        .mat_a     (mat_a),
        .mat_b     (mat_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_mat   (res_mat),
        .overflow  (overflow)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: exact integer matrix product, round half up, clamp to word range.
    function automatic void model(input mat_t a, input mat_t b, output mat_t r, output logic ov);
        longint s;
        longint maxv = (longint'(1) <<< (W - 1)) - 1;
        longint minv = -(longint'(1) <<< (W - 1));
        ov = 1'b0;
        r  = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) begin
                    s += longint'($signed(a[i*N+k])) * longint'($signed(b[k*N+j]));
                end
                s = (s + (longint'(1) <<< (WIF - 1))) >>> WIF;
                if (s > maxv) begin
                    s  = maxv;
                    ov = 1'b1;
                end else if (s < minv) begin
                    s  = minv;
                    ov = 1'b1;
                end
                r[i*N+j] = s[W-1:0];
            end
        end
    endfunction

    function automatic mat_t diag(input logic [W-1:0] v);
        mat_t m = '0;
        for (int i = 0; i < N; i++) m[i*N+i] = v;
        return m;
    endfunction

    function automatic mat_t fill(input logic [W-1:0] v);
        mat_t m;
        for (int i = 0; i < NE; i++) m[i] = v;
        return m;
    endfunction

    // Every cycle a result is presented it must match the model.
    always @(negedge Clk) begin
        if (out_valid === 1'b1) begin
            check("done_res", res_mat, exp_res);
            check("done_ovf", overflow, exp_ovf);
        end
    end

    task automatic accept(input mat_t a, input mat_t b, input logic ch);
        int n = 0;
        @(negedge Clk);
        mat_a = a; mat_b = b; chain = ch; in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check("accept_ready", in_ready, 1'b1);
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        chain    = 1'b0;
        model(ch ? model_res : a, b, exp_res, exp_ovf);
        model_res = exp_res;
    endtask

    task automatic wait_done(input string name);
        int cyc;
        for (cyc = 1; cyc <= 100; cyc++) begin
            @(posedge Clk);
            #1;
            if (out_valid === 1'b1) break;
        end
        check(name, cyc, NE);
    endtask

    task automatic handoff();
        @(negedge Clk);
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 1'b0;
        check("handoff_ready", in_ready, 1'b1);
        check("handoff_valid", out_valid, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; in_valid = 1'b0; chain = 1'b0; out_ready = 1'b0;
        mat_a = '0; mat_b = '0;
        exp_res = '0; model_res = '0; exp_ovf = 1'b0;
        for (int i = 0; i < NE; i++) ramp[i] = W'(i * 256);

        repeat (2) @(posedge Clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_res", res_mat, '0);
        check("rst_ovf", overflow, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;

        // Identity times ramp
        accept(diag(16'h0100), ramp, 1'b0);
        wait_done("lat_ident");
        check("ident_lit", res_mat, ramp);
        check("ident_ovf_lit", overflow, 1'b0);
        handoff();

        // Saturation both ways
        accept(fill(16'h7F00), fill(16'h0200), 1'b0);
        wait_done("lat_satp");
        check("satp_lit", res_mat, fill(16'h7FFF));
        check("satp_ovf_lit", overflow, 1'b1);
        handoff();
        accept(fill(16'h8100), fill(16'h0200), 1'b0);
        wait_done("lat_satn");
        check("satn_lit", res_mat, fill(16'h8000));
        check("satn_ovf_lit", overflow, 1'b1);
        handoff();

        // Rounding at the half-LSB boundary
        ma = '0; ma[0] = 16'h0001;
        mb = '0; mb[0] = 16'h0080;
        accept(ma, mb, 1'b0);
        wait_done("lat_rnd1");
        check("rnd_half_up_lit", res_mat[0], 16'h0001);
        check("rnd_ovf_lit", overflow, 1'b0);
        handoff();
        mb[0] = 16'h007F;
        accept(ma, mb, 1'b0);
        wait_done("lat_rnd2");
        check("rnd_below_lit", res_mat[0], 16'h0000);
        handoff();
        mb[0] = 16'hFF80;
        accept(ma, mb, 1'b0);
        wait_done("lat_rnd3");
        check("rnd_neg_half_lit", res_mat[0], 16'h0000);
        handoff();

        // 2I, then back-pressure with a chained 3I operation waiting
        accept(diag(16'h0200), diag(16'h0100), 1'b0);
        wait_done("lat_p");
        check("p_lit", res_mat, diag(16'h0200));
        held = res_mat;
        @(negedge Clk);
        in_valid = 1'b1; chain = 1'b1;
        mat_a = fill(16'h1234); mat_b = diag(16'h0300);
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk);
            #1;
            check("bp_stable", res_mat, held);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
        end
        @(negedge Clk);
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 1'b0;
        check("bp_handoff_ready", in_ready, 1'b1);
        check("bp_handoff_valid", out_valid, 1'b0);
        @(posedge Clk);
        #1;
        check("bp_accepted", in_ready, 1'b0);
        in_valid = 1'b0; chain = 1'b0;
        model(model_res, diag(16'h0300), exp_res, exp_ovf);
        model_res = exp_res;
        wait_done("lat_chain");
        check("chain_lit", res_mat, diag(16'h0600));
        handoff();

        // Reset in the middle of BUSY, then chain from the cleared result
        accept(fill(16'h0100), ramp, 1'b0);
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_res = '0; exp_res = '0; exp_ovf = 1'b0;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_res", res_mat, '0);
        check("midrst_ovf", overflow, 1'b0);
        accept(fill(16'h5555), diag(16'h0300), 1'b1);
        wait_done("lat_post_rst");
        check("post_rst_chain_lit", res_mat, '0);
        handoff();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
